// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - shared constants and types for the ATM PIN keypad
// Purpose: key-code constants, FSM state enum, default parameter values and
//          a digit-classification helper shared by the keypad top and timer.
// Ports:   none (package)
package atm_pkg;

  localparam int DEF_TIMEOUT_CYCLES = 50000;
  localparam int DEF_MAX_ATTEMPTS   = 3;

  localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
  localparam logic [3:0] KEY_CLEAR     = 4'hA;
  localparam logic [3:0] KEY_BACKSPACE = 4'hB;
  localparam logic [3:0] KEY_ENTER     = 4'hC;
  localparam logic [3:0] KEY_CANCEL    = 4'hD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_READY   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_t;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_DIGIT_MAX;
  endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// rtl/atm_timeout_ctr.sv - saturating inter-key idle timer
// Purpose: counts idle cycles while run=1; clr restarts the count.
// Ports:   clk, rst_n (async active-low), clr, run in; expire out, high for
//          the cycle whose clock edge brings the count to LIMIT-1.
module atm_timeout_ctr #(
  parameter int LIMIT = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  // expire is flagged one count early so the owner acts on the same edge
  // that the count reaches LIMIT-1.
  localparam logic [15:0] PRE_LIMIT = 16'(LIMIT - 2);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (run && (cnt != 16'hFFFF)) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expire = run && (cnt == PRE_LIMIT);

endmodule

// File: rtl/atm_pin_keypad.sv
// rtl/atm_pin_keypad.sv - ATM PIN entry keypad controller
// Purpose: collects a 4-digit BCD PIN from key strobes, presents it for a
//          verdict, counts rejected attempts and locks out the card.
// Ports:   clk, rst_n (async active-low); card_inserted, enable, key_valid,
//          key_code[3:0], pin_ok, pin_reject in; pin_input[15:0], pin_ready,
//          digit_count[2:0], key_err/cancel/timeout pulses, card_retain,
//          attempts[1:0] out.
module atm_pin_keypad
  import atm_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_inserted,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        pin_ok,
  input  logic        pin_reject,
  output logic [15:0] pin_input,
  output logic        pin_ready,
  output logic [2:0]  digit_count,
  output logic        key_err,
  output logic        cancel,
  output logic        timeout,
  output logic        card_retain,
  output logic [1:0]  attempts
);

  state_t      state, state_nxt;
  logic [15:0] buffer, buffer_nxt;
  logic [2:0]  count, count_nxt;
  logic [1:0]  attempts_nxt;
  logic [2:0]  attempts_inc;
  logic        key_err_nxt, cancel_nxt, timeout_nxt;
  logic        tmr_clr, tmr_run, tmr_expire;

  always_comb begin
    state_nxt    = state;
    buffer_nxt   = buffer;
    count_nxt    = count;
    attempts_nxt = attempts;
    key_err_nxt  = 1'b0;
    cancel_nxt   = 1'b0;
    timeout_nxt  = 1'b0;
    attempts_inc = {1'b0, attempts} + 3'd1;

    case (state)
      ST_IDLE: begin
        if (enable && card_inserted) begin
          state_nxt  = ST_COLLECT;
          buffer_nxt = '0;
          count_nxt  = '0;
        end
      end

      ST_COLLECT: begin
        // Card removal outranks everything, then loss of enable, then keys.
        if (!card_inserted) begin
          state_nxt    = ST_IDLE;
          buffer_nxt   = '0;
          count_nxt    = '0;
          attempts_nxt = '0;
        end else if (!enable) begin
          state_nxt  = ST_IDLE;
          buffer_nxt = '0;
          count_nxt  = '0;
        end else if (key_valid) begin
          if (is_digit(key_code)) begin
            if (count < 3'd4) begin
              buffer_nxt = {buffer[11:0], key_code};
              count_nxt  = count + 3'd1;
            end else begin
              key_err_nxt = 1'b1;
            end
          end else begin
            case (key_code)
              KEY_CLEAR: begin
                buffer_nxt = '0;
                count_nxt  = '0;
              end
              KEY_BACKSPACE: begin
                // Digits are right-aligned, so dropping the last one is a right shift.
                if (count != 3'd0) begin
                  buffer_nxt = {4'h0, buffer[15:4]};
                  count_nxt  = count - 3'd1;
                end
              end
              KEY_ENTER: begin
                if (count == 3'd4) state_nxt = ST_READY;
                else               key_err_nxt = 1'b1;
              end
              KEY_CANCEL: begin
                cancel_nxt = 1'b1;
                state_nxt  = ST_IDLE;
                buffer_nxt = '0;
                count_nxt  = '0;
              end
              default: key_err_nxt = 1'b1;
            endcase
          end
        end else if (tmr_expire) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_IDLE;
          buffer_nxt  = '0;
          count_nxt   = '0;
        end
      end

      ST_READY: begin
        if (!card_inserted) begin
          state_nxt    = ST_IDLE;
          buffer_nxt   = '0;
          count_nxt    = '0;
          attempts_nxt = '0;
        end else if (pin_reject) begin
          attempts_nxt = attempts_inc[1:0];
          buffer_nxt   = '0;
          count_nxt    = '0;
          state_nxt    = (attempts_inc == 3'(MAX_ATTEMPTS)) ? ST_LOCKED : ST_COLLECT;
        end else if (pin_ok) begin
          state_nxt    = ST_IDLE;
          buffer_nxt   = '0;
          count_nxt    = '0;
          attempts_nxt = '0;
        end
      end

      ST_LOCKED: begin
        if (!card_inserted) begin
          state_nxt    = ST_IDLE;
          attempts_nxt = '0;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  // Timer runs only while collecting; it restarts on entry and on any key.
  assign tmr_run = (state == ST_COLLECT);
  assign tmr_clr = ((state != ST_COLLECT) && (state_nxt == ST_COLLECT)) ||
                   ((state == ST_COLLECT) && key_valid);

  atm_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .run   (tmr_run),
    .expire(tmr_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      buffer   <= '0;
      count    <= '0;
      attempts <= '0;
      key_err  <= 1'b0;
      cancel   <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      buffer   <= buffer_nxt;
      count    <= count_nxt;
      attempts <= attempts_nxt;
      key_err  <= key_err_nxt;
      cancel   <= cancel_nxt;
      timeout  <= timeout_nxt;
    end
  end

  assign pin_input   = (state == ST_READY) ? buffer : 16'h0000;
  assign pin_ready   = (state == ST_READY);
  assign card_retain = (state == ST_LOCKED);
  assign digit_count = count;

endmodule

// File: doc/atm_pin_keypad.md
ATM_PIN_KEYPAD -- requirements
Module: atm_pin_keypad

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, the number of idle clock cycles allowed between keys in COLLECT.
REQ-002 The block SHALL have parameter MAX_ATTEMPTS, default 3, the number of rejected PINs that triggers lockout.
REQ-003 The block SHALL have port clk, input, 1, system clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset: asynchronous, active-low.
REQ-005 The block SHALL have port card_inserted, input, 1, card present in slot.
REQ-006 The block SHALL have port enable, input, 1, controller is in PIN entry and requests a PIN.
REQ-007 The block SHALL have port key_valid, input, 1, single-cycle key strobe.
REQ-008 The block SHALL have port key_code, input, 4, key code: 0x0-0x9 digit, 0xA clear, 0xB backspace, 0xC enter, 0xD cancel, 0xE-0xF illegal.
REQ-009 The block SHALL have port pin_ok / pin_reject, input, 1 each, controller verdict on the presented PIN.
REQ-010 The block SHALL have port pin_input, output, 16, 4-digit BCD PIN with the first digit in [15:12].
REQ-011 The block SHALL have port pin_ready, output, 1, PIN presented and awaiting verdict.
REQ-012 The block SHALL have port digit_count, output, 3, number of digits buffered (0-4).
REQ-013 The block SHALL have ports key_err / cancel / timeout, output, 1 each, single-cycle pulses.
REQ-014 The block SHALL have port card_retain, output, 1, lockout: swallow the card.
REQ-015 The block SHALL have port attempts, output, 2, rejected-PIN count.

Function
REQ-016 The block SHALL implement an FSM with states IDLE, COLLECT, READY and LOCKED, all registered on clk.
REQ-017 In IDLE, when enable=1 and card_inserted=1, the FSM SHALL move to COLLECT with the buffer=0 and digit_count=0.
REQ-018 In COLLECT, a digit key with count<4 SHALL shift the buffer left 4 bits, insert the digit in [3:0] and increment count, with the result visible the next cycle.
REQ-019 A digit key with count=4 SHALL leave the buffer unchanged and pulse key_err for 1 cycle.
REQ-020 Backspace SHALL shift the buffer right 4 bits and decrement count; with count=0 it SHALL have no effect and no error.
REQ-021 Clear SHALL zero the buffer and count.
REQ-022 Illegal codes 0xE-0xF SHALL pulse key_err and change nothing else.
REQ-023 Enter with count=4 SHALL move the FSM to READY and assert pin_ready the next cycle.
REQ-024 Enter with count<4 SHALL pulse key_err and keep the FSM in COLLECT.
REQ-025 Cancel SHALL pulse cancel, clear the buffer and move the FSM to IDLE.
REQ-026 The idle counter SHALL clear on entering COLLECT and on every key_valid, and increment otherwise; reaching TIMEOUT_CYCLES-1 SHALL pulse timeout, clear the buffer and move the FSM to IDLE.
REQ-027 The idle counter SHALL be 16 bits wide and SHALL saturate, never wrap.
REQ-028 pin_input SHALL carry the buffer only in READY and SHALL be 16'h0000 in every other state.
REQ-029 In READY, pin_ready SHALL be held 1, key_valid SHALL be ignored, and the idle counter SHALL be frozen.
REQ-030 pin_ok in READY SHALL clear attempts and the buffer, drop pin_ready and move the FSM to IDLE.
REQ-031 pin_reject in READY SHALL increment attempts; if the new value equals MAX_ATTEMPTS the FSM SHALL go to LOCKED, otherwise to COLLECT with the buffer cleared.
REQ-032 If pin_ok and pin_reject arrive in the same cycle, reject SHALL take priority.
REQ-033 pin_ok or pin_reject outside READY SHALL be ignored.
REQ-034 In LOCKED, card_retain SHALL be 1, all keys SHALL be ignored, and card_inserted=0 SHALL move the FSM to IDLE and clear attempts.
REQ-035 card_inserted=0 in COLLECT or READY SHALL move the FSM to IDLE and clear the buffer, count and attempts, with no pulse outputs.
REQ-036 enable=0 in COLLECT SHALL move the FSM to IDLE and clear the buffer while retaining attempts.
REQ-037 When a key and card removal occur in the same cycle, card removal SHALL take priority.
REQ-038 The pulse outputs SHALL be registered and SHALL last exactly 1 cycle.

Reset
REQ-039 rst_n=0 SHALL asynchronously force state=IDLE, buffer=0, digit_count=0, attempts=0 and the idle counter=0.
REQ-040 rst_n=0 SHALL asynchronously force pin_input=0, pin_ready=0, key_err=0, cancel=0, timeout=0 and card_retain=0.
REQ-041 Reset applied mid-entry or during LOCKED SHALL discard all state, with no pulse on release.
REQ-042 Reset deassertion SHALL be synchronized to clk externally; the block SHALL register outputs from the first clk edge after release.

Structure
REQ-043 The shared package atm_pkg SHALL hold the key-code constants, the FSM state enum and the default TIMEOUT_CYCLES and MAX_ATTEMPTS values.
REQ-044 The idle timer SHALL be a single sub-module, atm_timeout_ctr, with inputs clr and run, an expire pulse output, and parameter LIMIT.

Verification
REQ-045 With card in and enable=1, keys 1,2,3,4,enter SHALL produce pin_input=16'h1234 and pin_ready=1; pin_ok SHALL then give pin_input=0, pin_ready=0, state IDLE and attempts=0.
REQ-046 Keys 5,6,backspace,7,8,9,enter SHALL produce pin_input=16'h5789; a fifth digit SHALL pulse key_err with the buffer unchanged.
REQ-047 Keys 1,2,enter SHALL pulse key_err and hold digit_count=2; 0xE SHALL pulse key_err only.
REQ-048 Three consecutive pin_reject responses SHALL set attempts=3 and card_retain=1; card_inserted=0 SHALL then give IDLE, attempts=0 and card_retain=0.
REQ-049 With TIMEOUT_CYCLES=8, one digit followed by 7 idle cycles SHALL pulse timeout and clear digit_count.
REQ-050 rst_n low for 1 cycle mid-entry after 3 digits SHALL asynchronously zero all outputs, with no stray pulse after release.
REQ-051 card_inserted=0 coincident with an enter key SHALL give IDLE with no pin_ready.
REQ-052 Simultaneous pin_ok and pin_reject SHALL increment attempts.
